pc_ctrl: RTL and testbench

Fetch-stage controller that sequences the program-counter register. It decides each cycle whether the PC updates (o_pc_write) and to what value (o_next_pc). It arbitrates exception, branch, jump, load-use stall and instruction-memory wait, and holds a pending redirect across memory waits. It sits between the hazard/branch logic in ID/EX, the instruction memory handshake, and the PC register's write-enable and input.

---
 rtl/pipe_pkg.sv | 27 ++
 rtl/pc_redirect_arb.sv | 47 ++++
 rtl/pc_ctrl.sv | 125 ++++++++++++
 tb/tb_pc_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared fetch-pipeline definitions: PC controller state encoding, instruction
// size, and redirect-source select codes also used by the hazard unit.
package pipe_pkg;

  localparam int INSN_BYTES = 4;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_WAIT = 2'd2
  } pc_state_e;

  typedef enum logic [2:0] {
    SEL_SEQ    = 3'd0,
    SEL_PEND   = 3'd1,
    SEL_JUMP   = 3'd2,
    SEL_BRANCH = 3'd3,
    SEL_EXC    = 3'd4
  } redir_sel_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] target;
    logic        flush_ex;
  } redir_t;

endpackage

// File: rtl/pc_redirect_arb.sv
// Priority mux over the live redirect inputs: exception > branch > jump.
// Pending and sequential sources are resolved by the caller.
module pc_redirect_arb
  import pipe_pkg::*;
#(
  parameter logic [31:0] EXC_VEC = 32'h8000_0004
) (
  input  logic        exception,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output redir_t      redir
);

  redir_sel_e sel;

  always_comb begin
    sel = SEL_SEQ;
    if (exception)         sel = SEL_EXC;
    else if (branch_taken) sel = SEL_BRANCH;
    else if (jump)         sel = SEL_JUMP;
  end

  always_comb begin
    redir = '0;
    case (sel)
      SEL_EXC: begin
        redir.valid    = 1'b1;
        redir.target   = EXC_VEC;
        redir.flush_ex = 1'b1;
      end
      SEL_BRANCH: begin
        redir.valid    = 1'b1;
        redir.target   = branch_target;
        redir.flush_ex = 1'b1;
      end
      // A jump resolves in ID, so only the IF/ID slot holds a wrong-path op.
      SEL_JUMP: begin
        redir.valid  = 1'b1;
        redir.target = jump_target;
      end
      default: redir = '0;
    endcase
  end

endmodule

// File: rtl/pc_ctrl.sv
// Fetch-stage PC sequencer: boot delay, redirect arbitration, pending redirect
// held across instruction-memory waits, and a saturating stall counter.
//
// state | meaning
// BOOT  | post-reset idle, counting down to the first fetch
// RUN   | fetching, last request was accepted
// WAIT  | fetching, instruction memory not ready yet
module pc_ctrl
  import pipe_pkg::*;
#(
  parameter logic [31:0] RESET_VEC   = 32'h0000_0000,
  parameter logic [31:0] EXC_VEC     = 32'h8000_0004,
  parameter int          BOOT_CYCLES = 4,
  parameter int          CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      i_pc,
  input  logic             i_load_use_stall,
  input  logic             i_jump,
  input  logic [31:0]      i_jump_target,
  input  logic             i_branch_taken,
  input  logic [31:0]      i_branch_target,
  input  logic             i_exception,
  input  logic             i_imem_ready,
  output logic             o_imem_req,
  output logic             o_pc_write,
  output logic [31:0]      o_next_pc,
  output logic             o_if_id_flush,
  output logic             o_id_ex_flush,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic [1:0]       o_state
);

  pc_state_e   state, state_n;
  logic [3:0]  boot_cnt;
  logic        pending_valid, pending_valid_n;
  logic [31:0] pending_target, pending_target_n;
  logic        stall_inc;
  redir_t      redir;

  pc_redirect_arb #(.EXC_VEC(EXC_VEC)) u_arb (
    .exception    (i_exception),
    .branch_taken (i_branch_taken),
    .branch_target(i_branch_target),
    .jump         (i_jump),
    .jump_target  (i_jump_target),
    .redir        (redir)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_BOOT;
      boot_cnt       <= '0;
      pending_valid  <= 1'b0;
      pending_target <= '0;
      o_stall_cnt    <= '0;
    end else begin
      state          <= state_n;
      pending_valid  <= pending_valid_n;
      pending_target <= pending_target_n;
      if (state == ST_BOOT)
        boot_cnt <= boot_cnt + 4'd1;
      if (stall_inc && (o_stall_cnt != {CNT_W{1'b1}}))
        o_stall_cnt <= o_stall_cnt + 1'b1;
    end
  end

  always_comb begin
    state_n          = state;
    pending_valid_n  = pending_valid;
    pending_target_n = pending_target;
    o_imem_req       = 1'b0;
    o_pc_write       = 1'b0;
    o_next_pc        = RESET_VEC;
    o_if_id_flush    = 1'b0;
    o_id_ex_flush    = 1'b0;
    stall_inc        = 1'b0;

    if (!reset) begin
      case (state)
        ST_BOOT: begin
          if (boot_cnt == 4'(BOOT_CYCLES - 1)) begin
            o_pc_write = 1'b1;
            state_n    = ST_RUN;
          end
        end
        ST_RUN, ST_WAIT: begin
          o_imem_req = 1'b1;
          o_next_pc  = i_pc + 32'(INSN_BYTES);
          if (redir.valid) begin
            o_if_id_flush = 1'b1;
            o_id_ex_flush = redir.flush_ex;
            if (i_imem_ready) begin
              o_pc_write      = 1'b1;
              o_next_pc       = redir.target;
              pending_valid_n = 1'b0;
              state_n         = ST_RUN;
            end else begin
              pending_valid_n  = 1'b1;
              pending_target_n = redir.target;
              state_n          = ST_WAIT;
            end
          end else if (!i_imem_ready) begin
            state_n = ST_WAIT;
          end else if (pending_valid) begin
            o_pc_write      = 1'b1;
            o_next_pc       = pending_target;
            o_if_id_flush   = 1'b1;
            pending_valid_n = 1'b0;
            state_n         = ST_RUN;
          end else begin
            o_pc_write = !i_load_use_stall;
            state_n    = ST_RUN;
          end
          stall_inc = !o_pc_write;
        end
        default: state_n = ST_BOOT;
      endcase
    end
  end

  assign o_state = state;

endmodule

// File: tb/tb_pc_ctrl.sv
// Directed bench for pc_ctrl: boot, redirect priority, pending across waits,
// PC wrap, stall-counter saturation and reset during a pending wait.
module tb_pc_ctrl;

  logic        clk;
  logic        reset;
  logic [31:0] i_pc;
  logic        i_load_use_stall;
  logic        i_jump;
  logic [31:0] i_jump_target;
  logic        i_branch_taken;
  logic [31:0] i_branch_target;
  logic        i_exception;
  logic        i_imem_ready;
  logic        o_imem_req;
  logic        o_pc_write;
  logic [31:0] o_next_pc;
  logic        o_if_id_flush;
  logic        o_id_ex_flush;
  logic [3:0]  o_stall_cnt;
  logic [1:0]  o_state;

  int tests_run;
  int tests_failed;

  pc_ctrl #(
    .RESET_VEC  (32'h0000_0000),
    .EXC_VEC    (32'h8000_0004),
    .BOOT_CYCLES(4),
    .CNT_W      (4)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .i_pc            (i_pc),
    .i_load_use_stall(i_load_use_stall),
    .i_jump          (i_jump),
    .i_jump_target   (i_jump_target),
    .i_branch_taken  (i_branch_taken),
    .i_branch_target (i_branch_target),
    .i_exception     (i_exception),
    .i_imem_ready    (i_imem_ready),
    .o_imem_req      (o_imem_req),
    .o_pc_write      (o_pc_write),
    .o_next_pc       (o_next_pc),
    .o_if_id_flush   (o_if_id_flush),
    .o_id_ex_flush   (o_id_ex_flush),
    .o_stall_cnt     (o_stall_cnt),
    .o_state         (o_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Outputs settle after the last input change, well clear of the next edge.
  task automatic settle();
    #1;
  endtask

  task automatic clear_redirects();
    i_jump           = 1'b0;
    i_branch_taken   = 1'b0;
    i_exception      = 1'b0;
    i_load_use_stall = 1'b0;
  endtask

  initial begin
    tests_run        = 0;
    tests_failed     = 0;
    reset            = 1'b1;
    i_pc             = 32'h0;
    i_jump_target    = 32'h0;
    i_branch_target  = 32'h0;
    i_imem_ready     = 1'b0;
    clear_redirects();

    tick();
    settle();
    chk("rst_state", 32'(o_state), 32'd0);
    chk("rst_cnt", 32'(o_stall_cnt), 32'd0);
    chk("rst_pcw", 32'(o_pc_write), 32'd0);
    chk("rst_req", 32'(o_imem_req), 32'd0);
    chk("rst_npc", o_next_pc, 32'h0);

    // Boot: cycles 1..3 idle, cycle 4 writes RESET_VEC
    reset = 1'b0;
    i_imem_ready = 1'b1;
    settle();
    chk("boot1_pcw", 32'(o_pc_write), 32'd0);
    chk("boot1_req", 32'(o_imem_req), 32'd0);
    tick();
    chk("boot2_pcw", 32'(o_pc_write), 32'd0);
    tick();
    chk("boot3_pcw", 32'(o_pc_write), 32'd0);
    tick();
    i_jump = 1'b1;
    i_jump_target = 32'h0000_0999;
    settle();
    chk("boot4_pcw", 32'(o_pc_write), 32'd1);
    chk("boot4_npc", o_next_pc, 32'h0);
    chk("boot4_flush", 32'(o_if_id_flush), 32'd0);
    tick();
    clear_redirects();
    settle();
    chk("run_state", 32'(o_state), 32'd1);
    chk("boot_nostall", 32'(o_stall_cnt), 32'd0);

    // Sequential fetch
    i_pc = 32'h0;
    settle();
    chk("seq0_npc", o_next_pc, 32'h4);
    chk("seq0_pcw", 32'(o_pc_write), 32'd1);
    chk("seq0_flush", 32'({o_if_id_flush, o_id_ex_flush}), 32'd0);
    tick();
    i_pc = 32'h4;
    settle();
    chk("seq1_npc", o_next_pc, 32'h8);
    tick();

    // Jump overrides load-use stall
    i_pc = 32'h100;
    i_load_use_stall = 1'b1;
    i_jump = 1'b1;
    i_jump_target = 32'h200;
    settle();
    chk("sj_pcw", 32'(o_pc_write), 32'd1);
    chk("sj_npc", o_next_pc, 32'h200);
    chk("sj_ifid", 32'(o_if_id_flush), 32'd1);
    chk("sj_idex", 32'(o_id_ex_flush), 32'd0);
    tick();

    // Plain load-use stall
    i_jump = 1'b0;
    settle();
    chk("stall_pcw", 32'(o_pc_write), 32'd0);
    tick();
    chk("stall_cnt1", 32'(o_stall_cnt), 32'd1);
    chk("stall_state", 32'(o_state), 32'd1);

    // Priority: exception beats branch and jump
    i_load_use_stall = 1'b0;
    i_exception = 1'b1;
    i_branch_taken = 1'b1;
    i_branch_target = 32'h300;
    i_jump = 1'b1;
    i_jump_target = 32'h400;
    settle();
    chk("prio_npc", o_next_pc, 32'h8000_0004);
    chk("prio_flush", 32'({o_if_id_flush, o_id_ex_flush}), 32'd3);
    i_exception = 1'b0;
    settle();
    chk("prio_br_npc", o_next_pc, 32'h300);
    chk("prio_br_idex", 32'(o_id_ex_flush), 32'd1);
    tick();

    // Branch during memory wait becomes pending
    clear_redirects();
    i_imem_ready = 1'b0;
    i_branch_taken = 1'b1;
    i_branch_target = 32'h500;
    i_pc = 32'h108;
    settle();
    chk("pend_pcw0", 32'(o_pc_write), 32'd0);
    chk("pend_flush0", 32'({o_if_id_flush, o_id_ex_flush}), 32'd3);
    tick();
    i_branch_taken = 1'b0;
    for (int k = 0; k < 3; k++) begin
      settle();
      chk("pend_pcw", 32'(o_pc_write), 32'd0);
      chk("pend_state", 32'(o_state), 32'd2);
      chk("pend_ifid", 32'(o_if_id_flush), 32'd0);
      tick();
    end
    chk("pend_cnt", 32'(o_stall_cnt), 32'd5);
    i_imem_ready = 1'b1;
    settle();
    chk("pend_apply_pcw", 32'(o_pc_write), 32'd1);
    chk("pend_apply_npc", o_next_pc, 32'h500);
    chk("pend_apply_ifid", 32'(o_if_id_flush), 32'd1);
    chk("pend_apply_idex", 32'(o_id_ex_flush), 32'd0);
    tick();
    chk("pend_run", 32'(o_state), 32'd1);

    // Sequential wrap
    i_pc = 32'hFFFF_FFFC;
    settle();
    chk("wrap_npc", o_next_pc, 32'h0);
    chk("wrap_ifid", 32'(o_if_id_flush), 32'd0);
    tick();

    // Saturation: 20 stalled cycles from 5
    i_imem_ready = 1'b0;
    for (int k = 0; k < 20; k++) tick();
    chk("sat_cnt", 32'(o_stall_cnt), 32'd15);
    chk("sat_state", 32'(o_state), 32'd2);

    // Reset mid-WAIT with a pending jump
    i_jump = 1'b1;
    i_jump_target = 32'h700;
    tick();
    i_jump = 1'b0;
    reset = 1'b1;
    settle();
    chk("rstw_req", 32'(o_imem_req), 32'd0);
    chk("rstw_npc", o_next_pc, 32'h0);
    tick();
    chk("rstw_state", 32'(o_state), 32'd0);
    chk("rstw_cnt", 32'(o_stall_cnt), 32'd0);
    reset = 1'b0;
    i_imem_ready = 1'b1;
    i_pc = 32'h0;
    for (int k = 0; k < 3; k++) begin
      settle();
      chk("reboot_idle", 32'(o_pc_write), 32'd0);
      tick();
    end
    settle();
    chk("reboot_pcw", 32'(o_pc_write), 32'd1);
    chk("reboot_npc", o_next_pc, 32'h0);
    tick();
    settle();
    chk("reboot_seq", o_next_pc, 32'h4);
    chk("reboot_noflush", 32'(o_if_id_flush), 32'd0);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
